round_ctrl: RTL
===============

Name: round_ctrl

Overview:
- Game-round controller that sits directly downstream of the digit generator.
- Drives the generator's seed_en from the first start press, then latches its four digits (0-9, 10 = wildcard) as the round target.
- Collects a 4-digit player guess under a countdown timer, scores the round, and exports target, timer and score to the display stage.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per countdown second (>=2)
ROUND_SECS, 10, round duration in seconds (1-255)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle pulse (already debounced), begins a round
entry_valid  in  1  single-cycle pulse, entry_digit valid
entry_digit  in  4  player digit; values 10-15 ignored
d0,d1,d2,d3  in  4 each  generator digits, 0-9 or 10 (wildcard)
seed_en  out  1  seed request to generator
tgt0,tgt1,tgt2,tgt3  out  4 each  latched target digits
guess_pos  out  2  index of next guess digit
busy  out  1  high in LOAD, ENTRY, CHECK
time_left  out  8  seconds remaining
match  out  4  per-position match flags, valid in DONE
win  out  1  level, last round won
lose  out  1  level, last round lost
round_done  out  1  one-cycle pulse on entry to DONE
score  out  SCORE_W  rounds won

Behaviour:
- Reset (async): all outputs 0, state IDLE, guess regs 0, tick counter 0. Reset mid-round aborts the round; score clears.
- States: IDLE, LOAD, ENTRY, CHECK, DONE.
- IDLE: start -> LOAD; seed_en <= 1 and holds 1 until rst.
- LOAD: exactly 2 cycles, so a freshly seeded generator's registered digits are valid.
  - On the 2nd cycle: tgtN <= dN, guess_pos <= 0, time_left <= ROUND_SECS, tick counter <= 0, win/lose/match <= 0.
  - Then -> ENTRY. start is ignored in LOAD.
- ENTRY:
  - entry_valid with entry_digit <= 9: guess[guess_pos] <= entry_digit; guess_pos increments.
  - When the 4th digit is accepted (guess_pos was 3): guess_pos wraps to 0, -> CHECK.
  - entry_digit >= 10: no effect. start is ignored.
  - Timer: tick counter runs 0..TICKS_PER_SEC-1. On wrap, time_left decrements.
  - When time_left is 1 and the tick wraps: time_left <= 0, lose <= 1, match <= 0, -> DONE.
  - Simultaneous 4th entry and timeout in the same cycle: the entry wins, -> CHECK, time_left is not decremented.
- CHECK: one cycle.
  - match[i] = (tgt_i == 10) or (guess[i] == tgt_i); i=0 is the first digit entered, compared with tgt0.
  - All four match: win <= 1 and score increments, saturating at 2^SCORE_W-1.
  - Otherwise: lose <= 1.
  - -> DONE.
- DONE: round_done high for exactly the first cycle. win, lose, match, targets and time_left hold. start -> LOAD (new round); entry_valid is ignored.
- Latency: start to busy = 1 cycle; start to targets valid = 3 cycles; 4th entry to win/lose = 2 cycles.
- win and lose are never high together.

Optional Feature:
PENALTY_EN:
- Defined: every lost round (mismatch or timeout) decrements score by 1, saturating at 0, in the same cycle lose is set.
- Undefined: score is unchanged on a loss.

Test Plan:
- TICKS_PER_SEC=4, ROUND_SECS=3, rst then start at cycle 10 -> seed_en=1 at cycle 11 and stays 1; busy=1 at cycle 11; tgt0-3 equal d0-d3 sampled at cycle 12.
- Drive d={3,7,1,9}, start, enter 3,7,1,9 -> CHECK then match=4'b1111, win=1, score=1, round_done pulses 1 cycle.
- d={10,2,10,5}, enter 8,2,0,5 -> match=4'b1111 (wildcards), win=1. Enter 8,3,0,5 -> match=4'b1101, lose=1, score unchanged; with PENALTY_EN, score decrements.
- No entries after start -> time_left 3,2,1,0 at 4-cycle intervals; lose=1 when it reaches 0; round_done pulses.
- 4th entry on the exact timeout cycle -> CHECK taken, time_left stays 1.
- entry_digit=12 ignored (guess_pos unchanged); start during ENTRY ignored; rst during ENTRY -> all outputs 0, state IDLE, seed_en=0.

Source files
------------

// File: rtl/round_ctrl_if.sv
// round_ctrl_if: signal bundle between the game-round controller and its
// neighbours (digit generator upstream, player input, display downstream).
//
//   master modport (player/generator/display side):
//     drives  start, entry_valid, entry_digit, d0..d3
//     reads   seed_en, tgt0..tgt3, guess_pos, busy, time_left, match,
//             win, lose, round_done, score
//   slave modport (round_ctrl side): the mirror image.
//
// SCORE_W must match the SCORE_W of the round_ctrl instance it connects to.
interface round_ctrl_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               entry_valid;
  logic [3:0]         entry_digit;
  logic [3:0]         d0, d1, d2, d3;
  logic               seed_en;
  logic [3:0]         tgt0, tgt1, tgt2, tgt3;
  logic [1:0]         guess_pos;
  logic               busy;
  logic [7:0]         time_left;
  logic [3:0]         match;
  logic               win;
  logic               lose;
  logic               round_done;
  logic [SCORE_W-1:0] score;

  modport master (
    output start, entry_valid, entry_digit, d0, d1, d2, d3,
    input  seed_en, tgt0, tgt1, tgt2, tgt3, guess_pos, busy, time_left,
           match, win, lose, round_done, score
  );

  modport slave (
    input  start, entry_valid, entry_digit, d0, d1, d2, d3,
    output seed_en, tgt0, tgt1, tgt2, tgt3, guess_pos, busy, time_left,
           match, win, lose, round_done, score
  );
endinterface

// File: rtl/round_ctrl.sv
// round_ctrl: game-round controller placed after the digit generator.
//   Requests a seed on the first start, latches the generator's four digits
//   (0-9, 10 = wildcard) as the target, collects a 4-digit guess under a
//   countdown, scores the round and exports target/timer/score for display.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset (aborts a round, clears score)
//   bus  round_ctrl_if.slave: start/entry_valid/entry_digit/d0..d3 in;
//        seed_en, tgt0..3, guess_pos, busy, time_left, match, win, lose,
//        round_done, score out
//
// Parameters: TICKS_PER_SEC (>=2) clocks per countdown second, ROUND_SECS
//   (1-255) round length, SCORE_W score width (must match the interface).
//
// Build option: define PENALTY_EN to decrement the score (saturating at 0)
//   on every lost round; without it a loss leaves the score unchanged.
module round_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int ROUND_SECS    = 10,
  parameter int SCORE_W       = 8
) (
  input logic         clk,
  input logic         rst,
  round_ctrl_if.slave bus
);

  localparam int                  TICK_W     = $clog2(TICKS_PER_SEC);
  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]          ROUND_TIME = 8'(ROUND_SECS);
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = '1;
  localparam logic [3:0]          WILDCARD   = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENTRY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic               load_second;  // second of the two LOAD cycles
  logic [TICK_W-1:0]  tick;
  logic [3:0]         guess [4];
  logic [3:0]         tgt [4];
  logic               seed_en;
  logic [1:0]         guess_pos;
  logic [7:0]         time_left;
  logic [3:0]         match;
  logic               win;
  logic               lose;
  logic               round_done;
  logic [SCORE_W-1:0] score;
  logic               busy;

  logic               accept;       // legal digit offered during ENTRY
  logic               last_digit;   // accept of the 4th digit
  logic               timeout;      // final second expires, no 4th digit
  logic [3:0]         match_now;
  logic               win_now;
  logic               lose_now;

  assign accept     = (state == S_ENTRY) && bus.entry_valid && (bus.entry_digit <= 4'd9);
  assign last_digit = accept && (guess_pos == 2'd3);
  // A 4th digit arriving on the expiry cycle wins over the timeout.
  assign timeout    = (state == S_ENTRY) && (tick == TICK_LAST) &&
                      (time_left == 8'd1) && !last_digit;

  // Next state and busy.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_LOAD;
      S_LOAD: begin
        busy = 1'b1;
        if (load_second) state_nx = S_ENTRY;
      end
      S_ENTRY: begin
        busy = 1'b1;
        if (last_digit)   state_nx = S_CHECK;
        else if (timeout) state_nx = S_DONE;
      end
      S_CHECK: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE:  if (bus.start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Position i is the i-th digit entered, compared with target digit i.
  always_comb begin
    match_now = '0;
    for (int i = 0; i < 4; i++)
      match_now[i] = (tgt[i] == WILDCARD) || (guess[i] == tgt[i]);
  end

  assign win_now  = (state == S_CHECK) && (&match_now);
  assign lose_now = ((state == S_CHECK) && !(&match_now)) || timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the guess and target arrays are small register files that
      // must read as zero after reset, so they are reset explicitly.
      for (int i = 0; i < 4; i++) begin
        guess[i] <= '0;
        tgt[i]   <= '0;
      end
      load_second <= 1'b0;
      tick        <= '0;
      seed_en     <= 1'b0;
      guess_pos   <= '0;
      time_left   <= '0;
      match       <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      round_done  <= 1'b0;
    end else begin
      round_done <= 1'b0;
      // seed_en rises with the first start and stays up until reset.
      if (state_nx == S_LOAD) seed_en <= 1'b1;

      case (state)
        S_LOAD: begin
          load_second <= !load_second;
          if (load_second) begin
            for (int i = 0; i < 4; i++) tgt[i] <= '0;
            tgt[0]    <= bus.d0;
            tgt[1]    <= bus.d1;
            tgt[2]    <= bus.d2;
            tgt[3]    <= bus.d3;
            guess_pos <= '0;
            time_left <= ROUND_TIME;
            tick      <= '0;
            match     <= '0;
            win       <= 1'b0;
            lose      <= 1'b0;
          end
        end
        S_ENTRY: begin
          if (accept) begin
            guess[guess_pos] <= bus.entry_digit;
            guess_pos        <= guess_pos + 2'd1;  // 3 wraps to 0
          end
          if (!last_digit) begin
            if (tick == TICK_LAST) begin
              tick      <= '0;
              time_left <= time_left - 8'd1;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          if (timeout) begin
            lose       <= 1'b1;
            match      <= '0;
            round_done <= 1'b1;
          end
        end
        S_CHECK: begin
          match      <= match_now;
          win        <= win_now;
          lose       <= !win_now;
          round_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
    end else if (win_now) begin
      if (score != SCORE_MAX) score <= score + 1'b1;
    end
`ifdef PENALTY_EN
    else if (lose_now) begin
      if (score != '0) score <= score - 1'b1;
    end
`endif
  end

`ifndef PENALTY_EN
  // lose_now only feeds the penalty path; keep it referenced in this build.
  logic unused_lose_now;
  assign unused_lose_now = lose_now;
`endif

  assign bus.seed_en    = seed_en;
  assign bus.tgt0       = tgt[0];
  assign bus.tgt1       = tgt[1];
  assign bus.tgt2       = tgt[2];
  assign bus.tgt3       = tgt[3];
  assign bus.guess_pos  = guess_pos;
  assign bus.busy       = busy;
  assign bus.time_left  = time_left;
  assign bus.match      = match;
  assign bus.win        = win;
  assign bus.lose       = lose;
  assign bus.round_done = round_done;
  assign bus.score      = score;

endmodule
